pmem_arbiter: RTL
=================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single 256-bit physical-memory port between the I-cache and D-cache line-fill paths.
//  Sits between the two caches and the pmem_* pins of the top-level CPU.
//  Grants one cache-line transaction at a time, round-robin on conflict.
//  Latches the granted request, returns the read line registered, and converts
//  pm_error or a stalled memory into an error response to the requester.
// PARAMETERS
//  ADDR_W     32    pmem address width
//  LINE_W     256   cache line width
//  TIMEOUT    1023  max BUSY cycles without pmem_resp before error; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous reset, active-high
//  i_read         in   1       I-cache line read request, held until i_resp
//  i_address      in   ADDR_W  I-cache line address
//  i_rdata        out  LINE_W  line returned to I-cache, valid with i_resp
//  i_resp         out  1       one-cycle completion pulse to I-cache
//  i_error        out  1       with i_resp: transaction failed, i_rdata undefined
//  d_read         in   1       D-cache line read request, held until d_resp
//  d_write        in   1       D-cache line writeback request, held until d_resp
//  d_address      in   ADDR_W  D-cache line address
//  d_wdata        in   LINE_W  writeback line
//  d_rdata        out  LINE_W  line returned to D-cache, valid with d_resp
//  d_resp         out  1       one-cycle completion pulse to D-cache
//  d_error        out  1       with d_resp: transaction failed
//  pmem_read      out  1       read command to physical memory
//  pmem_write     out  1       write command to physical memory
//  pmem_address   out  ADDR_W  registered address to physical memory
//  pmem_wdata     out  LINE_W  registered write line to physical memory
//  pmem_rdata     in   LINE_W  line from physical memory, valid with pmem_resp
//  pmem_resp      in   1       physical memory completion
//  pm_error       in   1       physical memory error, terminates transaction
// BEHAVIOUR
//  States: IDLE, BUSY, RESP. Reset -> IDLE, last_grant=I, all outputs 0, counters 0.
//  IDLE: pending_i=i_read; pending_d=d_read|d_write. None -> stay.
//   One pending -> grant it. Both -> grant side != last_grant (first tie after reset goes to D).
//   On grant (edge ending IDLE cycle N): latch owner, address, op (d_write wins if d_read&d_write),
//   wdata; update last_grant; clear timer; -> BUSY. pmem_read/pmem_write asserted from cycle N+1.
//  BUSY: pmem_read/pmem_write/pmem_address/pmem_wdata driven only from latched regs,
//   insensitive to requester inputs. Exactly one of pmem_read/pmem_write high.
//   pmem_resp & !pm_error -> capture pmem_rdata (reads), err=0, -> RESP.
//   pm_error (regardless of pmem_resp) -> err=1, -> RESP.
//   timer==TIMEOUT with neither -> err=1, -> RESP. Else timer++ (saturating, no wrap).
//  RESP: exactly one cycle; pmem_read=pmem_write=0; owner's x_resp=1, x_error=err,
//   x_rdata=captured line (held stable until the next capture). Non-owner resp=0. -> IDLE.
//  Requester drops request the cycle after x_resp; the RESP->IDLE gap guarantees no
//   re-grant of a stale request. Min turnaround: request cycle N -> pmem cmd N+1 -> resp pulse
//   one cycle after pmem_resp -> next grant earliest one cycle after that.
//  i_resp and d_resp never high together. pmem_read and pmem_write never high together.
//  Write transactions return d_rdata unchanged (prior value).
//  rst mid-BUSY: next cycle IDLE, pmem commands low, transaction dropped with no resp pulse.
//  Requests rising during BUSY/RESP wait; arbitration uses values sampled in IDLE only.
// TESTING
//  1 i_read only, A=0x0000_1000; pmem_resp 3 cycles later w/ line L -> pmem_read 1 cyc after
//    req, pmem_address=0x1000, i_resp=1 with i_rdata=L, i_error=0, d_resp stays 0.
//  2 i_read & d_read same cycle after reset -> D served first, then I; repeat tie -> D,I
//    alternate; pmem_address switches only between transactions.
//  3 d_write A=0x2000, wdata=0xA5..A5 -> pmem_write=1, pmem_wdata=0xA5..A5; d_address changed
//    to 0x3000 during BUSY -> pmem_address stays 0x2000; d_resp=1, d_error=0.
//  4 pm_error pulse in BUSY of I read -> i_resp=1, i_error=1; next request proceeds normally.
//  5 no pmem_resp with TIMEOUT=15 -> error resp exactly 16 BUSY cycles after grant, pmem_read low next.
//  6 rst asserted in BUSY -> next cycle all outputs 0, no resp; request retried, served normally.

Source files
------------

// File: rtl/pmem_arbiter.sv
// ----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares the single physical-memory port between the I-cache and D-cache
// line-fill paths. One cache-line transaction is in flight at a time; when both
// caches ask in the same idle cycle the side that was not granted last wins.
// The granted request is latched so that pmem_* stays stable while memory
// works, and the returned line is registered per requester. A pm_error, or
// memory going quiet for too long, becomes an error response to the requester.
//
// Parameters
//   ADDR_W   pmem address width
//   LINE_W   cache line width
//   TIMEOUT  max BUSY cycles without pmem_resp before an error response
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_read, i_address         I-cache line read request (held until i_resp)
//   i_rdata, i_resp, i_error  I-cache completion (one-cycle pulse)
//   d_read, d_write           D-cache line read / writeback request
//   d_address, d_wdata        D-cache request address and writeback line
//   d_rdata, d_resp, d_error  D-cache completion (one-cycle pulse)
//   pmem_read, pmem_write     command to physical memory
//   pmem_address, pmem_wdata  latched address / write line to memory
//   pmem_rdata, pmem_resp     line and completion from memory
//   pm_error                  memory error, terminates the transaction
// ----------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    output logic              i_error,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              d_error,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              pm_error
);

    localparam int              TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               owner_d;       // 1: current transaction belongs to the D-cache
    logic               last_grant_d;  // side granted most recently, for round-robin
    logic               op_write;
    logic               err_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  i_line_q;
    logic [LINE_W-1:0]  d_line_q;
    logic [TMR_W-1:0]   timer;

    logic               pending_i;
    logic               pending_d;
    logic               grant_valid;
    logic               grant_d;
    logic               busy_ok;
    logic               busy_err;

    // Arbitration and BUSY completion decode. Requests are only looked at in
    // IDLE, so anything that rises during BUSY/RESP simply waits its turn.
    always_comb begin
        pending_i   = i_read;
        pending_d   = d_read | d_write;
        grant_valid = 1'b0;
        grant_d     = 1'b0;
        busy_ok     = 1'b0;
        busy_err    = 1'b0;
        state_next  = state;

        case (state)
            IDLE: begin
                if (pending_i && pending_d) begin
                    grant_valid = 1'b1;
                    grant_d     = ~last_grant_d;
                end else if (pending_d) begin
                    grant_valid = 1'b1;
                    grant_d     = 1'b1;
                end else if (pending_i) begin
                    grant_valid = 1'b1;
                    grant_d     = 1'b0;
                end
                if (grant_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // pm_error overrides a simultaneous pmem_resp; the timeout only
                // fires when memory has said nothing at all this cycle.
                busy_ok  = pmem_resp & ~pm_error;
                busy_err = pm_error | (~pmem_resp & (timer == TMR_MAX));
                if (busy_ok || busy_err) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the latched transaction. The RESP->IDLE gap gives the
    // requester a cycle to drop its request before the next arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner_d      <= 1'b0;
            last_grant_d <= 1'b0;
            op_write     <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_line_q     <= '0;
            d_line_q     <= '0;
            timer        <= '0;
        end else begin
            state <= state_next;

            if (grant_valid) begin
                owner_d      <= grant_d;
                last_grant_d <= grant_d;
                op_write     <= grant_d & d_write;
                addr_q       <= grant_d ? d_address : i_address;
                if (grant_d) begin
                    wdata_q <= d_wdata;
                end
                timer <= '0;
                err_q <= 1'b0;
            end

            if (state == BUSY) begin
                if (busy_ok) begin
                    err_q <= 1'b0;
                    // Writebacks leave the D-side line untouched.
                    if (!op_write) begin
                        if (owner_d) begin
                            d_line_q <= pmem_rdata;
                        end else begin
                            i_line_q <= pmem_rdata;
                        end
                    end
                end else if (busy_err) begin
                    err_q <= 1'b1;
                end else if (timer != TMR_MAX) begin
                    timer <= timer + TMR_W'(1);
                end
            end
        end
    end

    // Memory-side outputs come only from latched state, never from the caches.
    assign pmem_read    = (state == BUSY) & ~op_write;
    assign pmem_write   = (state == BUSY) &  op_write;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state == RESP) & ~owner_d;
    assign d_resp  = (state == RESP) &  owner_d;
    assign i_error = i_resp & err_q;
    assign d_error = d_resp & err_q;
    assign i_rdata = i_line_q;
    assign d_rdata = d_line_q;

endmodule
